// File: rtl/exp6_fluxo_dados.sv
// Memory-game datapath: round/address counters, play register, sequence ROM, LEDs, press edge detect.
// Status flags are combinational from registers; define EXP6_TIMEOUT_EN to build the play timeout counter.
module exp6_fluxo_dados #(
  parameter int N_RODADAS      = 16,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       zeraCR,
  input  logic       contaCR,
  input  logic       zeraE,
  input  logic       contaE,
  input  logic       limpaRC,
  input  logic       registraRC,
  input  logic       zeraLeds,
  input  logic       registraLeds,
  input  logic       led_selector,
  input  logic       contaT,
  output logic       fim,
  output logic       jogada,
  output logic       jogada_correta,
  output logic       enderecoIgualRodada,
  output logic       timeout,
  output logic [3:0] leds,
  output logic [3:0] db_rodada,
  output logic [3:0] db_contagem,
  output logic [3:0] db_jogada,
  output logic [3:0] db_memoria
);

  localparam logic [3:0] ULTIMA_RODADA = 4'(N_RODADAS - 1);

  logic [3:0] cr;
  logic [3:0] e;
  logic [3:0] rc;
  logic [3:0] led_reg;
  logic [3:0] rom_dado;
  logic       botao_d;
  logic       algum_botao;

  assign algum_botao = |botoes;

  // Clear wins over increment; both counters wrap naturally at 4 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cr <= 4'd0;
    end else if (zeraCR) begin
      cr <= 4'd0;
    end else if (contaCR) begin
      cr <= cr + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e <= 4'd0;
    end else if (zeraE) begin
      e <= 4'd0;
    end else if (contaE) begin
      e <= e + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rc <= 4'd0;
    end else if (limpaRC) begin
      rc <= 4'd0;
    end else if (registraRC) begin
      rc <= botoes;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_reg <= 4'd0;
    end else if (zeraLeds) begin
      led_reg <= 4'd0;
    end else if (registraLeds) begin
      led_reg <= led_selector ? rom_dado : botoes;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botao_d <= 1'b0;
    end else begin
      botao_d <= algum_botao;
    end
  end

  // Fixed game sequence, one-hot button per step.
  always_comb begin
    rom_dado = 4'h1;
    case (e)
      4'd0:  rom_dado = 4'h1;
      4'd1:  rom_dado = 4'h2;
      4'd2:  rom_dado = 4'h4;
      4'd3:  rom_dado = 4'h8;
      4'd4:  rom_dado = 4'h4;
      4'd5:  rom_dado = 4'h2;
      4'd6:  rom_dado = 4'h1;
      4'd7:  rom_dado = 4'h1;
      4'd8:  rom_dado = 4'h2;
      4'd9:  rom_dado = 4'h2;
      4'd10: rom_dado = 4'h4;
      4'd11: rom_dado = 4'h4;
      4'd12: rom_dado = 4'h8;
      4'd13: rom_dado = 4'h1;
      4'd14: rom_dado = 4'h2;
      4'd15: rom_dado = 4'h4;
      default: rom_dado = 4'h1;
    endcase
  end

`ifdef EXP6_TIMEOUT_EN
  localparam logic [15:0] T_MAX = 16'(TIMEOUT_CICLOS - 1);
  logic [15:0] t_cnt;

  // Restarts whenever the FSM leaves the wait state; saturates so timeout holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t_cnt <= 16'd0;
    end else if (!contaT) begin
      t_cnt <= 16'd0;
    end else if (t_cnt != T_MAX) begin
      t_cnt <= t_cnt + 16'd1;
    end
  end

  assign timeout = contaT & (t_cnt == T_MAX);
`else
  logic unused_contat;
  assign unused_contat = contaT;
  assign timeout       = 1'b0;
`endif

  assign fim                 = (cr == ULTIMA_RODADA);
  assign jogada              = algum_botao & ~botao_d;
  assign jogada_correta      = (rc == rom_dado);
  assign enderecoIgualRodada = (e == cr);
  assign leds                = led_reg;
  assign db_rodada           = cr;
  assign db_contagem         = e;
  assign db_jogada           = rc;
  assign db_memoria          = rom_dado;

endmodule

// File: tb/tb_exp6_fluxo_dados.sv
// Randomized bench for exp6_fluxo_dados with a behavioural model and directed literal checks.
module tb_exp6_fluxo_dados;

  localparam int NR = 16;
  localparam int TC = 5;
`ifdef EXP6_TIMEOUT_EN
  localparam bit T_EN = 1'b1;
`else
  localparam bit T_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes = 4'd0;
  logic       zeraCR = 0, contaCR = 0, zeraE = 0, contaE = 0;
  logic       limpaRC = 0, registraRC = 0, zeraLeds = 0, registraLeds = 0;
  logic       led_selector = 0, contaT = 0;
  logic       fim, jogada, jogada_correta, enderecoIgualRodada, timeout;
  logic [3:0] leds, db_rodada, db_contagem, db_jogada, db_memoria;

  int errors = 0;
  int checks = 0;

  exp6_fluxo_dados #(.N_RODADAS(NR), .TIMEOUT_CICLOS(TC)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraCR(zeraCR), .contaCR(contaCR), .zeraE(zeraE), .contaE(contaE),
    .limpaRC(limpaRC), .registraRC(registraRC),
    .zeraLeds(zeraLeds), .registraLeds(registraLeds),
    .led_selector(led_selector), .contaT(contaT),
    .fim(fim), .jogada(jogada), .jogada_correta(jogada_correta),
    .enderecoIgualRodada(enderecoIgualRodada), .timeout(timeout),
    .leds(leds), .db_rodada(db_rodada), .db_contagem(db_contagem),
    .db_jogada(db_jogada), .db_memoria(db_memoria)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game state as plain integers.
  int rom [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 1, 2, 4};
  int m_cr, m_e, m_rc, m_leds, m_run;
  bit m_prev;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cr = 0; m_e = 0; m_rc = 0; m_leds = 0; m_run = 0; m_prev = 0;
    end else begin
      if (limpaRC) m_rc = 0;
      else if (registraRC) m_rc = int'(botoes);
      if (zeraLeds) m_leds = 0;
      else if (registraLeds) m_leds = led_selector ? rom[m_e] : int'(botoes);
      if (zeraCR) m_cr = 0;
      else if (contaCR) m_cr = (m_cr + 1) % 16;
      if (zeraE) m_e = 0;
      else if (contaE) m_e = (m_e + 1) % 16;
      m_prev = (botoes != 4'd0);
      // m_run = consecutive clocks contaT has been seen high
      if (!contaT) m_run = 0;
      else if (m_run < 1000000) m_run = m_run + 1;
    end
  end

  always @(negedge clock) begin
    check("fim", int'(fim), int'(m_cr == NR - 1));
    check("jogada", int'(jogada), int'((botoes != 4'd0) && !m_prev));
    check("jogada_correta", int'(jogada_correta), int'(m_rc == rom[m_e]));
    check("enderecoIgualRodada", int'(enderecoIgualRodada), int'(m_e == m_cr));
    check("timeout", int'(timeout), int'(T_EN && contaT && m_run >= TC - 1));
    check("leds", int'(leds), m_leds);
    check("db_rodada", int'(db_rodada), m_cr);
    check("db_contagem", int'(db_contagem), m_e);
    check("db_jogada", int'(db_jogada), m_rc);
    check("db_memoria", int'(db_memoria), rom[m_e]);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first, hi;

    // Reset values
    @(negedge clock);
    check("rst_fim", int'(fim), 0);
    check("rst_eq", int'(enderecoIgualRodada), 1);
    check("rst_correta", int'(jogada_correta), 0);
    check("rst_leds", int'(leds), 0);
    check("rst_timeout", int'(timeout), 0);
    tick();
    reset = 0;
    tick();

    // Reset mid-count
    contaCR = 1; ticks(3); contaCR = 0;
    contaE = 1; ticks(2); contaE = 0;
    check("pre_rst_cr", int'(db_rodada), 3);
    check("pre_rst_e", int'(db_contagem), 2);
    reset = 1;
    #1;
    check("mid_rst_cr", int'(db_rodada), 0);
    check("mid_rst_e", int'(db_contagem), 0);
    check("mid_rst_eq", int'(enderecoIgualRodada), 1);
    check("mid_rst_leds", int'(leds), 0);
    check("mid_rst_timeout", int'(timeout), 0);
    tick();
    reset = 0;
    tick();

    // Clear beats increment; E wraps after 16 increments
    contaCR = 1; ticks(2);
    zeraCR = 1; tick(); zeraCR = 0; contaCR = 0;
    check("clr_priority", int'(db_rodada), 0);
    contaE = 1; ticks(16); contaE = 0;
    check("e_wrap", int'(db_contagem), 0);
    contaCR = 1; ticks(15); contaCR = 0;
    check("cr15", int'(db_rodada), 15);
    check("fim_at_15", int'(fim), 1);
    zeraCR = 1; tick(); zeraCR = 0;

    // Play check at address 4
    contaE = 1; ticks(4); contaE = 0;
    check("rom4", int'(db_memoria), 4);
    botoes = 4'b0100; registraRC = 1; tick();
    check("rc4", int'(db_jogada), 4);
    check("correta_hit", int'(jogada_correta), 1);
    botoes = 4'b0010; tick(); registraRC = 0; botoes = 4'd0;
    check("correta_miss", int'(jogada_correta), 0);
    tick();

    // Held button gives one pulse, re-press gives another
    botoes = 4'b0001;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (jogada) pulses++;
    end
    check("held_pulses", pulses, 1);
    tick(); botoes = 4'd0; tick(); botoes = 4'b0001;
    @(negedge clock);
    check("repress_pulse", int'(jogada), 1);
    tick(); botoes = 4'd0;

    // LED sources
    zeraE = 1; tick(); zeraE = 0;
    contaE = 1; ticks(3); contaE = 0;
    led_selector = 1; registraLeds = 1; tick();
    check("leds_rom3", int'(leds), 8);
    led_selector = 0; botoes = 4'b0010; tick(); registraLeds = 0; botoes = 4'd0;
    check("leds_btn", int'(leds), 2);

    // Timeout window
    contaT = 1;
    first = 0; hi = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (timeout) begin
        if (first == 0) first = i;
        hi++;
      end
    end
    check("timeout_first_cycle", first, T_EN ? 5 : 0);
    check("timeout_held_cycles", hi, T_EN ? 4 : 0);
    tick(); contaT = 0;
    @(negedge clock);
    check("timeout_drop", int'(timeout), 0);
    tick(); contaT = 1;
    @(negedge clock);
    check("timeout_restart", int'(timeout), 0);
    tick(); contaT = 0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset        = ($urandom_range(199) == 0);
      zeraCR       = ($urandom_range(15) == 0);
      contaCR      = ($urandom_range(3) == 0);
      zeraE        = ($urandom_range(15) == 0);
      contaE       = ($urandom_range(2) == 0);
      limpaRC      = ($urandom_range(15) == 0);
      registraRC   = ($urandom_range(3) == 0);
      zeraLeds     = ($urandom_range(15) == 0);
      registraLeds = ($urandom_range(3) == 0);
      led_selector = $urandom_range(1);
      if ($urandom_range(11) == 0) contaT = ~contaT;
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(3))
          0, 1: botoes = 4'd0;
          2:    botoes = 4'(1 << $urandom_range(3));
          default: botoes = 4'($urandom_range(15));
        endcase
      end
    end
    tick();
    reset = 0; contaT = 0;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
